fe_req_ctrl: RTL and testbench

- Parametrised successor to the fixed three-line front-end request word (ptr/ptp/dis data requests packed into a 32-bit status).
- Synchronises up to 32 device request lines from the PDP-6 peripheral emulations.
- Latches each line as a sticky pending bit (edge mode) or tracks it live (level mode), with per-channel mask.
- Exposes an Avalon-MM slave register file to the HPS front end: priority "next request" lookup, atomic claim-on-read, and an interrupt line, replacing polling of a raw word.

---
 rtl/fe_req_pkg.sv | 20 ++
 rtl/fe_req_ctrl_sync_bits.sv | 31 +++
 rtl/fe_req_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fe_req_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fe_req_pkg.sv
// Shared constants for the front-end request controller register file.
package fe_req_pkg;

  // Register word addresses
  localparam logic [2:0] REG_RAW   = 3'd0;
  localparam logic [2:0] REG_PEND  = 3'd1;
  localparam logic [2:0] REG_MASK  = 3'd2;
  localparam logic [2:0] REG_MODE  = 3'd3;
  localparam logic [2:0] REG_NEXT  = 3'd4;
  localparam logic [2:0] REG_CLAIM = 3'd5;
  localparam logic [2:0] REG_COUNT = 3'd6;

  // NEXT/CLAIM word layout
  localparam int unsigned NEXT_VALID_BIT = 31;
  localparam int unsigned IDX_W          = 5;

  // Edge event counter width
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/fe_req_ctrl_sync_bits.sv
// Multi-bit flip-flop synchroniser with synchronous reset. Each bit is an
// independent request line, so no bus coherence is required.
module sync_bits #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift chain; stage 0 captures the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(STAGES); s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int s = 1; s < int'(STAGES); s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fe_req_ctrl.sv
// Front-end request controller: synchronises device request lines, keeps
// per-channel pending state (sticky edge or live level), and exposes a
// register file with priority lookup, claim-on-read and an interrupt.
module fe_req_ctrl
  import fe_req_pkg::*;
#(
  parameter int unsigned NCHAN       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCHAN-1:0] fe_rq,
  input  logic [2:0]       s_address,
  input  logic             s_read,
  input  logic             s_write,
  input  logic [31:0]      s_writedata,
  output logic [31:0]      s_readdata,
  output logic             irq,
  output logic [NCHAN-1:0] rq_leds
);

  // Lowest set bit wins
  function automatic logic [IDX_W-1:0] prio_idx(input logic [NCHAN-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Zero-extend a channel vector to a register word
  function automatic logic [31:0] zext(input logic [NCHAN-1:0] v);
    logic [31:0] w;
    w = '0;
    w[NCHAN-1:0] = v;
    return w;
  endfunction

  logic [NCHAN-1:0] raw, raw_d_q;
  logic [NCHAN-1:0] pend_q, pend_d;
  logic [NCHAN-1:0] mask_q, mask_d;
  logic [NCHAN-1:0] mode_q, mode_d;
  logic [NCHAN-1:0] act, rise, edge_ev, w1c, claim_clr, wdata_ch;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   count_sum;
  logic [5:0]       n_ev;
  logic [IDX_W-1:0] act_idx;
  logic             act_valid;
  logic [31:0]      next_word;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q;
  logic             claim_rd;
  logic             unused_wdata;

  sync_bits #(
    .WIDTH  (NCHAN),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (fe_rq),
    .q     (raw)
  );

  assign wdata_ch     = s_writedata[NCHAN-1:0];
  assign unused_wdata = ^s_writedata;

  assign act       = pend_q & mask_q;
  assign act_valid = |act;
  assign act_idx   = prio_idx(act);
  assign rise      = raw & ~raw_d_q;
  assign edge_ev   = rise & ~mode_q;
  assign claim_rd  = s_read && (s_address == REG_CLAIM);

  // NEXT word: valid flag at the top, channel index in the low bits
  always_comb begin
    next_word = '0;
    if (act_valid) begin
      next_word[NEXT_VALID_BIT] = 1'b1;
      next_word[IDX_W-1:0]      = act_idx;
    end
  end

  // Pending, mask and mode next-state; a new rising edge beats any clear
  always_comb begin
    w1c       = (s_write && (s_address == REG_PEND)) ? wdata_ch : '0;
    claim_clr = '0;
    for (int i = 0; i < int'(NCHAN); i++) begin
      claim_clr[i] = claim_rd && act_valid && (act_idx == IDX_W'(i));
    end
    for (int i = 0; i < int'(NCHAN); i++) begin
      if (mode_q[i]) begin
        pend_d[i] = raw[i];
      end else begin
        pend_d[i] = rise[i] | (pend_q[i] & ~(w1c[i] | claim_clr[i]));
      end
    end
    mask_d = (s_write && (s_address == REG_MASK)) ? wdata_ch : mask_q;
    mode_d = (s_write && (s_address == REG_MODE)) ? wdata_ch : mode_q;
  end

  // Saturating edge event counter; a clear still records same-cycle events
  always_comb begin
    n_ev = '0;
    for (int i = 0; i < int'(NCHAN); i++) begin
      n_ev = n_ev + 6'(edge_ev[i]);
    end
    count_sum = {1'b0, count_q} + (CNT_W + 1)'(n_ev);
    if (s_write && (s_address == REG_COUNT)) begin
      count_d = CNT_W'(n_ev);
    end else if (count_sum[CNT_W]) begin
      count_d = '1;
    end else begin
      count_d = count_sum[CNT_W-1:0];
    end
  end

  // Read mux; samples pre-write state so a concurrent write is not visible
  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      case (s_address)
        REG_RAW:   rdata_d = zext(raw);
        REG_PEND:  rdata_d = zext(pend_q);
        REG_MASK:  rdata_d = zext(mask_q);
        REG_MODE:  rdata_d = zext(mode_q);
        REG_NEXT:  rdata_d = next_word;
        REG_CLAIM: rdata_d = next_word;
        REG_COUNT: rdata_d = 32'(count_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_d_q <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      mode_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      raw_d_q <= raw;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      irq_q   <= act_valid;
    end
  end

  assign s_readdata = rdata_q;
  assign irq        = irq_q;
  assign rq_leds    = raw;

endmodule

// File: tb/tb_fe_req_ctrl.sv
// Directed bench for fe_req_ctrl (NCHAN=3, SYNC_STAGES=2). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_fe_req_ctrl;
  import fe_req_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  fe_rq;
  logic [2:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;
  logic [2:0]  rq_leds;

  int checks = 0;
  int errors = 0;

  fe_req_ctrl #(
    .NCHAN       (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fe_rq       (fe_rq),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .irq         (irq),
    .rq_leds     (rq_leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    tick();
    s_write     = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    s_address = a;
    s_read    = 1'b1;
    tick();
    s_read    = 1'b0;
    chk(tag, s_readdata, exp);
  endtask

  task automatic pulse(input int ch);
    fe_rq[ch] = 1'b1;
    repeat (5) tick();
    fe_rq[ch] = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    reset       = 1'b1;
    fe_rq       = '0;
    s_address   = '0;
    s_read      = 1'b0;
    s_write     = 1'b0;
    s_writedata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset defaults
    chk("rst_rdata", s_readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_leds", {29'b0, rq_leds}, 32'h0);
    rdchk("rst_mask", REG_MASK, 32'h7);
    rdchk("rst_pend", REG_PEND, 32'h0);
    rdchk("rst_next", REG_NEXT, 32'h0);
    rdchk("rst_count", REG_COUNT, 32'h0);
    rdchk("rst_mode", REG_MODE, 32'h0);

    // Edge latch timing on ch1 with PEND read every cycle
    s_address = REG_PEND;
    s_read    = 1'b1;
    fe_rq[1]  = 1'b1;
    tick();
    chk("lat_leds_e1", {29'b0, rq_leds}, 32'h0);
    chk("lat_pend_e1", s_readdata, 32'h0);
    tick();
    chk("lat_leds_e2", {29'b0, rq_leds}, 32'h2);
    chk("lat_pend_e2", s_readdata, 32'h0);
    tick();
    chk("lat_pend_e3", s_readdata, 32'h0);
    chk("lat_irq_e3", {31'b0, irq}, 32'h0);
    tick();
    chk("lat_pend_e4", s_readdata, 32'h2);
    chk("lat_irq_e4", {31'b0, irq}, 32'h1);
    s_read = 1'b0;
    tick();
    fe_rq[1] = 1'b0;
    repeat (4) tick();
    rdchk("lat_sticky", REG_PEND, 32'h2);
    rdchk("lat_next", REG_NEXT, 32'h8000_0001);
    wr(REG_PEND, 32'h2);
    chk("w1c_irq_w", {31'b0, irq}, 32'h1);
    tick();
    chk("w1c_irq_w1", {31'b0, irq}, 32'h0);
    rdchk("w1c_pend", REG_PEND, 32'h0);
    rdchk("lat_count", REG_COUNT, 32'h1);

    // Priority and claim
    pulse(2);
    pulse(0);
    rdchk("pri_next", REG_NEXT, 32'h8000_0000);
    rdchk("claim0", REG_CLAIM, 32'h8000_0000);
    rdchk("claim0_pend", REG_PEND, 32'h4);
    rdchk("claim2", REG_CLAIM, 32'h8000_0002);
    rdchk("claim2_pend", REG_PEND, 32'h0);
    rdchk("claim_empty", REG_CLAIM, 32'h0);

    // Mask
    wr(REG_MASK, 32'h6);
    pulse(0);
    rdchk("mask_pend", REG_PEND, 32'h1);
    chk("mask_irq", {31'b0, irq}, 32'h0);
    rdchk("mask_next", REG_NEXT, 32'h0);
    wr(REG_MASK, 32'h7);
    chk("unmask_irq_w", {31'b0, irq}, 32'h0);
    tick();
    chk("unmask_irq_w1", {31'b0, irq}, 32'h1);
    wr(REG_PEND, 32'h1);
    rdchk("mask_clr", REG_PEND, 32'h0);

    // Level mode on ch0
    wr(REG_MODE, 32'h1);
    fe_rq[0] = 1'b1;
    repeat (4) tick();
    rdchk("lvl_pend", REG_PEND, 32'h1);
    wr(REG_PEND, 32'h1);
    rdchk("lvl_w1c_ign", REG_PEND, 32'h1);
    s_address = REG_PEND;
    s_read    = 1'b1;
    fe_rq[0]  = 1'b0;
    repeat (3) tick();
    chk("lvl_drop_e3", s_readdata, 32'h1);
    tick();
    chk("lvl_drop_e4", s_readdata, 32'h0);
    s_read = 1'b0;
    rdchk("lvl_count", REG_COUNT, 32'h4);
    wr(REG_MODE, 32'h0);

    // Claim colliding with a new rising edge on ch1
    pulse(1);
    rdchk("col_pre", REG_PEND, 32'h2);
    fe_rq[1] = 1'b1;
    tick();
    tick();
    s_address = REG_CLAIM;
    s_read    = 1'b1;
    tick();
    s_read = 1'b0;
    chk("col_claim", s_readdata, 32'h8000_0001);
    rdchk("col_pend", REG_PEND, 32'h2);
    fe_rq[1] = 1'b0;
    wr(REG_PEND, 32'h2);
    rdchk("col_clr", REG_PEND, 32'h0);

    // Concurrent read/write and out-of-range bits
    s_address   = REG_MASK;
    s_writedata = 32'h3;
    s_read      = 1'b1;
    s_write     = 1'b1;
    tick();
    s_read  = 1'b0;
    s_write = 1'b0;
    chk("rw_pre", s_readdata, 32'h7);
    rdchk("rw_post", REG_MASK, 32'h3);
    wr(REG_MASK, 32'hFFFF_FFF8);
    rdchk("mask_hi", REG_MASK, 32'h0);
    wr(REG_MASK, 32'h7);
    rdchk("addr7", 3'd7, 32'h0);

    // Counter saturation: one edge-mode rise per cycle alternating ch0/ch1
    wr(REG_COUNT, 32'h0);
    rdchk("cnt_clr", REG_COUNT, 32'h0);
    for (int i = 0; i < 65540; i++) begin
      fe_rq = i[0] ? 3'b010 : 3'b001;
      tick();
    end
    fe_rq = '0;
    repeat (4) tick();
    rdchk("cnt_sat", REG_COUNT, 32'h0000_FFFF);
    wr(REG_COUNT, 32'h1234);
    rdchk("cnt_clr2", REG_COUNT, 32'h0);
    wr(REG_PEND, 32'h7);

    // Reset while a pulse is inside the synchroniser
    wr(REG_MASK, 32'h5);
    wr(REG_MODE, 32'h2);
    fe_rq[2] = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    fe_rq = '0;
    tick();
    reset = 1'b0;
    chk("mrst_irq", {31'b0, irq}, 32'h0);
    chk("mrst_leds", {29'b0, rq_leds}, 32'h0);
    chk("mrst_rdata", s_readdata, 32'h0);
    repeat (4) tick();
    rdchk("mrst_mask", REG_MASK, 32'h7);
    rdchk("mrst_mode", REG_MODE, 32'h0);
    rdchk("mrst_pend", REG_PEND, 32'h0);
    rdchk("mrst_next", REG_NEXT, 32'h0);
    rdchk("mrst_count", REG_COUNT, 32'h0);
    chk("mrst_irq2", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
